// File: rtl/btn_debounce_if.sv
// Pushbutton conditioner signal bundle: raw button in, debounced level, strobes and press count out.
// No backpressure: the strobes are one-cycle events that the consumer must sample on the cycle they are high.
interface btn_debounce_if;
   logic       btn_raw;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_count;

   modport master (
      output btn_raw,
      input  btn_level,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  press_count
   );

   modport slave (
      input  btn_raw,
      output btn_level,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output press_count
   );
endinterface

// File: rtl/btn_debounce.sv
// Pushbutton synchroniser, debouncer and press/release/long-press strobe generator.
// Long-press detection is built only when BTN_LONG_PRESS_EN is defined; otherwise long_pulse is tied to 0.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned LONG_CYCLES     = 100000000,
   parameter int unsigned CNT_W           = 27
) (
   input  logic          clk,
   input  logic          rst_n,
   btn_debounce_if.slave btn_if,
   output logic [1:0]    dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
      $error("btn_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be at least 1");
   end

   state_t           state_q;
   logic             s1_q;
   logic             btn_s_q;
   logic [CNT_W-1:0] dcnt_q;
   logic             level_q;
   logic             press_q;
   logic             release_q;
   logic [7:0]       count_q;
   logic             press_accept;
   logic             release_accept;

   // The input has been stable for the full debounce window on this edge.
   assign press_accept   = (state_q == PRESS_WAIT)   &&  btn_s_q && (dcnt_q == DEB_LAST);
   assign release_accept = (state_q == RELEASE_WAIT) && !btn_s_q && (dcnt_q == DEB_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_q      <= 1'b0;
         btn_s_q   <= 1'b0;
         state_q   <= IDLE;
         dcnt_q    <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         count_q   <= 8'd0;
      end else begin
         s1_q      <= btn_if.btn_raw;
         btn_s_q   <= s1_q;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (btn_s_q) begin
                  state_q <= PRESS_WAIT;
                  dcnt_q  <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!btn_s_q) begin
                  state_q <= IDLE;
               end else if (press_accept) begin
                  state_q <= HELD;
                  press_q <= 1'b1;
                  level_q <= 1'b1;
                  count_q <= count_q + 8'd1;
               end else begin
                  dcnt_q <= dcnt_q + CNT_W'(1);
               end
            end
            HELD: begin
               if (!btn_s_q) begin
                  state_q <= RELEASE_WAIT;
                  dcnt_q  <= '0;
               end
            end
            RELEASE_WAIT: begin
               if (btn_s_q) begin
                  state_q <= HELD;
               end else if (release_accept) begin
                  state_q   <= IDLE;
                  release_q <= 1'b1;
                  level_q   <= 1'b0;
               end else begin
                  dcnt_q <= dcnt_q + CNT_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef BTN_LONG_PRESS_EN
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_DONE = CNT_W'(LONG_CYCLES);

   logic [CNT_W-1:0] hcnt_q;
   logic             long_q;

   // hcnt parks at HOLD_DONE after firing so each press yields one long_pulse;
   // it only advances in HELD with the button still down, so release bounces pause it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hcnt_q <= '0;
         long_q <= 1'b0;
      end else begin
         long_q <= 1'b0;
         if (press_accept) begin
            hcnt_q <= '0;
         end else if (state_q == HELD && btn_s_q) begin
            if (hcnt_q == HOLD_LAST) begin
               long_q <= 1'b1;
               hcnt_q <= HOLD_DONE;
            end else if (hcnt_q < HOLD_LAST) begin
               hcnt_q <= hcnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign btn_if.long_pulse = long_q;
`else
   assign btn_if.long_pulse = 1'b0;
`endif

   assign btn_if.btn_level     = level_q;
   assign btn_if.press_pulse   = press_q;
   assign btn_if.release_pulse = release_q;
   assign btn_if.press_count   = count_q;
   assign dbg_state_o          = state_q;

endmodule
